time_set_ctrl: RTL and testbench

// - Parametrised time-setting engine for the digital clock: edits hour/minute/second fields with modulo wrap.
// - Supports up/down stepping, auto-repeat on held keys and 12h/24h hour range.
// - Sits between control_state_machine (set_time_en) and the timekeeping counter.
// - Loads current time on entry to set mode; issues a one-cycle commit pulse on exit.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/set_field_cnt.sv | 39 +++
 rtl/time_set_ctrl.sv | 158 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and field limits for the digital clock time-setting path.
package clock_pkg;

    // Field under edit; numeric values are visible on set_field.
    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_e;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR24_MAX = 23;
    localparam int HOUR12_MIN = 1;
    localparam int HOUR12_MAX = 12;

    // Field selection order: HOUR -> MIN -> SEC -> HOUR.
    function automatic field_e next_field(input field_e f);
        case (f)
            FLD_HOUR: next_field = FLD_MIN;
            FLD_MIN:  next_field = FLD_SEC;
            default:  next_field = FLD_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/set_field_cnt.sv
// One time field register with load and modulo up/down stepping.
module set_field_cnt #(
    parameter int W       = 6,
    parameter int MIN     = 0,
    parameter int MAX     = 59,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] C_MIN = W'(MIN);
    localparam logic [W-1:0] C_MAX = W'(MAX);
    localparam logic [W-1:0] C_RST = W'(RST_VAL);

    logic [W-1:0] r_value;

    // Load has priority; otherwise step with wrap between MIN and MAX.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= C_RST;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            r_value <= (r_value == C_MAX) ? C_MIN : r_value + W'(1);
        end else if (dec) begin
            r_value <= (r_value == C_MIN) ? C_MAX : r_value - W'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting engine: tracks the running time while idle, edits one field at
// a time in set mode with auto-repeat, and pulses set_time_load on exit.
module time_set_ctrl #(
    parameter int HOUR_24      = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time_en,
    input  logic       set_time_add,
    input  logic       set_time_sub,
    input  logic       set_time_shift,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [4:0] set_time_hour,
    output logic [5:0] set_time_minute,
    output logic [5:0] set_time_second,
    output logic [1:0] set_field,
    output logic       set_time_load
);

    import clock_pkg::*;

    localparam int HOUR_MIN = (HOUR_24 != 0) ? 0 : HOUR12_MIN;
    localparam int HOUR_MAX = (HOUR_24 != 0) ? HOUR24_MAX : HOUR12_MAX;
    localparam int HOUR_RST = (HOUR_24 != 0) ? 0 : HOUR12_MAX;

    localparam logic [4:0]       C_HOUR_MIN = 5'(HOUR_MIN);
    localparam logic [4:0]       C_HOUR_MAX = 5'(HOUR_MAX);
    localparam logic [CNT_W-1:0] C_DELAY    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] C_RATE     = CNT_W'(REPEAT_RATE);

    logic             r_en, r_add, r_sub, r_shift;
    logic             r_load;
    field_e           r_field;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_rep_on;

    logic       w_en_rise, w_en_fall, w_edit, w_shift_rise;
    logic       w_up, w_dn, w_key_one, w_key_edge, w_rep_hit, w_step;
    logic       w_inc, w_dec, w_load;
    logic [4:0] w_hour_load_val;

    // Edge detection against the previous-cycle key levels.
    assign w_en_rise    = set_time_en & ~r_en;
    assign w_en_fall    = ~set_time_en & r_en;
    assign w_edit       = set_time_en & r_en;
    assign w_shift_rise = w_edit & set_time_shift & ~r_shift;

    // Exactly one of add/sub held; a shift edge suppresses stepping that cycle.
    assign w_up       = set_time_add & ~set_time_sub;
    assign w_dn       = set_time_sub & ~set_time_add;
    assign w_key_one  = w_edit & (w_up | w_dn) & ~w_shift_rise;
    assign w_key_edge = w_key_one & ((w_up & ~r_add) | (w_dn & ~r_sub));
    assign w_rep_hit  = w_key_one & ~w_key_edge &
                        (r_rep_cnt == (r_rep_on ? C_RATE : C_DELAY));
    assign w_step     = w_key_edge | w_rep_hit;
    assign w_inc      = w_step & w_up;
    assign w_dec      = w_step & w_dn;

    // Track cur_* while idle and on entry; hold through the exit edge and the
    // commit pulse so the timekeeper sees the edited value.
    assign w_load = ~r_en & (set_time_en | ~r_load);

    // Entry clamps an out-of-range hour to the range minimum.
    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        w_hour_load_val = cur_hour;
        if (w_en_rise && ((cur_hour < C_HOUR_MIN) || (cur_hour > C_HOUR_MAX))) begin
            w_hour_load_val = C_HOUR_MIN;
        end
    end

    // Register key levels for edge detection and raise the commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_add   <= 1'b0;
            r_sub   <= 1'b0;
            r_shift <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_en    <= set_time_en;
            r_add   <= set_time_add;
            r_sub   <= set_time_sub;
            r_shift <= set_time_shift;
            r_load  <= w_en_fall;
        end
    end

    // Field select: back to HOUR on entry/exit, advance on shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_field <= FLD_HOUR;
        end else if (w_en_rise || w_en_fall) begin
            r_field <= FLD_HOUR;
        end else if (w_shift_rise) begin
            r_field <= next_field(r_field);
        end
    end

    // Repeat timer: restarts on a key edge, first fires after REPEAT_DELAY,
    // then every REPEAT_RATE; cleared whenever no single key is being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_rep_on  <= 1'b0;
        end else if (!w_key_one) begin
            r_rep_cnt <= '0;
            r_rep_on  <= 1'b0;
        end else if (w_key_edge) begin
            r_rep_cnt <= CNT_W'(1);
            r_rep_on  <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt <= CNT_W'(1);
            r_rep_on  <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
        end
    end

    set_field_cnt #(.W(5), .MIN(HOUR_MIN), .MAX(HOUR_MAX), .RST_VAL(HOUR_RST)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_hour_load_val),
        .inc      (w_inc & (r_field == FLD_HOUR)),
        .dec      (w_dec & (r_field == FLD_HOUR)),
        .value    (set_time_hour)
    );

    set_field_cnt #(.W(6), .MIN(0), .MAX(MIN_MAX), .RST_VAL(0)) u_minute (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (cur_minute),
        .inc      (w_inc & (r_field == FLD_MIN)),
        .dec      (w_dec & (r_field == FLD_MIN)),
        .value    (set_time_minute)
    );

    set_field_cnt #(.W(6), .MIN(0), .MAX(SEC_MAX), .RST_VAL(0)) u_second (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (cur_second),
        .inc      (w_inc & (r_field == FLD_SEC)),
        .dec      (w_dec & (r_field == FLD_SEC)),
        .value    (set_time_second)
    );

    assign set_field     = r_field;
    assign set_time_load = r_load;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench: a 24h and a 12h instance share stimulus; short repeat timing.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, add, sub, shift;
    logic [4:0] cur_h;
    logic [5:0] cur_m, cur_s;

    logic [4:0] h24, h12;
    logic [5:0] m24, s24, m12, s12;
    logic [1:0] f24, f12;
    logic       l24, l12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(.HOUR_24(1), .REPEAT_DELAY(10), .REPEAT_RATE(4), .CNT_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .set_time_en(en), .set_time_add(add),
        .set_time_sub(sub), .set_time_shift(shift), .cur_hour(cur_h),
        .cur_minute(cur_m), .cur_second(cur_s), .set_time_hour(h24),
        .set_time_minute(m24), .set_time_second(s24), .set_field(f24),
        .set_time_load(l24)
    );

    time_set_ctrl #(.HOUR_24(0), .REPEAT_DELAY(10), .REPEAT_RATE(4), .CNT_W(8)) dut12 (
        .clk(clk), .rst_n(rst_n), .set_time_en(en), .set_time_add(add),
        .set_time_sub(sub), .set_time_shift(shift), .cur_hour(cur_h),
        .cur_minute(cur_m), .cur_second(cur_s), .set_time_hour(h12),
        .set_time_minute(m12), .set_time_second(s12), .set_field(f12),
        .set_time_load(l12)
    );

    // Advance n rising edges; inputs change and outputs are sampled 1ns after.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_add();
        add = 1'b1; tick(1); add = 1'b0; tick(1);
    endtask

    task automatic pulse_sub();
        sub = 1'b1; tick(1); sub = 1'b0; tick(1);
    endtask

    task automatic pulse_shift();
        shift = 1'b1; tick(1); shift = 1'b0; tick(1);
    endtask

    task automatic enter(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_h = h; cur_m = m; cur_s = s;
        en = 1'b1; tick(1);
    endtask

    task automatic leave();
        en = 1'b0; tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; add = 0; sub = 0; shift = 0;
        cur_h = 5'd9; cur_m = 6'd9; cur_s = 6'd9;
        tick(2);
        total++;
        if ({h24, m24, s24, f24, l24} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_24 got %0d:%0d:%0d f=%0d l=%0d want 0:0:0 f=0 l=0", h24, m24, s24, f24, l24);
        end
        total++;
        if ({h12, l12} !== {5'd12, 1'b0}) begin
            bad++;
            $display("FAIL reset_12 got hour=%0d l=%0d want hour=12 l=0", h12, l12);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_entry();
        cur_h = 5'd10; cur_m = 6'd20; cur_s = 6'd30;
        tick(2);
        total++;
        if ({h24, m24, s24} !== {5'd10, 6'd20, 6'd30}) begin
            bad++;
            $display("FAIL idle_track got %0d:%0d:%0d want 10:20:30", h24, m24, s24);
        end
        enter(5'd10, 6'd20, 6'd30);
        total++;
        if ({h24, m24, s24, f24} !== {5'd10, 6'd20, 6'd30, 2'd0}) begin
            bad++;
            $display("FAIL entry_capture got %0d:%0d:%0d f=%0d want 10:20:30 f=0", h24, m24, s24, f24);
        end
        cur_h = 5'd3; cur_m = 6'd3; cur_s = 6'd3;
        tick(2);
        total++;
        if ({h24, m24, s24} !== {5'd10, 6'd20, 6'd30}) begin
            bad++;
            $display("FAIL edit_no_track got %0d:%0d:%0d want 10:20:30", h24, m24, s24);
        end
        pulse_add();
        pulse_add();
        total++;
        if ({h24, h12} !== {5'd12, 5'd12}) begin
            bad++;
            $display("FAIL entry_add2 got h24=%0d h12=%0d want 12 12", h24, h12);
        end
    endtask

    task automatic test_wrap();
        leave();
        enter(5'd12, 6'd59, 6'd0);
        pulse_shift();
        total++;
        if (f24 !== 2'd1) begin
            bad++;
            $display("FAIL wrap_field_min got %0d want 1", f24);
        end
        pulse_add();
        total++;
        if ({h24, m24} !== {5'd12, 6'd0}) begin
            bad++;
            $display("FAIL min_wrap_up got h=%0d m=%0d want h=12 m=0", h24, m24);
        end
        pulse_shift();
        pulse_sub();
        total++;
        if ({m24, s24} !== {6'd0, 6'd59}) begin
            bad++;
            $display("FAIL sec_wrap_down got m=%0d s=%0d want m=0 s=59", m24, s24);
        end
        pulse_shift();
        pulse_add();
        total++;
        if ({h12, h24} !== {5'd1, 5'd13}) begin
            bad++;
            $display("FAIL hour_up_12_to_1 got h12=%0d h24=%0d want 1 13", h12, h24);
        end
        pulse_sub();
        total++;
        if ({h12, h24} !== {5'd12, 5'd12}) begin
            bad++;
            $display("FAIL hour_down_1_to_12 got h12=%0d h24=%0d want 12 12", h12, h24);
        end
        leave();
        enter(5'd23, 6'd0, 6'd0);
        total++;
        if ({h24, h12} !== {5'd23, 5'd1}) begin
            bad++;
            $display("FAIL entry_clamp got h24=%0d h12=%0d want 23 1", h24, h12);
        end
        pulse_add();
        total++;
        if ({h24, h12} !== {5'd0, 5'd2}) begin
            bad++;
            $display("FAIL hour24_wrap_up got h24=%0d h12=%0d want 0 2", h24, h12);
        end
        pulse_sub();
        pulse_sub();
        total++;
        if ({h24, h12} !== {5'd22, 5'd12}) begin
            bad++;
            $display("FAIL hour_wrap_down got h24=%0d h12=%0d want 22 12", h24, h12);
        end
    endtask

    task automatic test_shift();
        leave();
        enter(5'd1, 6'd2, 6'd3);
        pulse_add();
        total++;
        if ({h24, m24, s24} !== {5'd2, 6'd2, 6'd3}) begin
            bad++;
            $display("FAIL shift_hour_only got %0d:%0d:%0d want 2:2:3", h24, m24, s24);
        end
        pulse_shift();
        pulse_add();
        total++;
        if ({f24, h24, m24, s24} !== {2'd1, 5'd2, 6'd3, 6'd3}) begin
            bad++;
            $display("FAIL shift_min_only got f=%0d %0d:%0d:%0d want f=1 2:3:3", f24, h24, m24, s24);
        end
        pulse_shift();
        pulse_add();
        total++;
        if ({f24, h24, m24, s24} !== {2'd2, 5'd2, 6'd3, 6'd4}) begin
            bad++;
            $display("FAIL shift_sec_only got f=%0d %0d:%0d:%0d want f=2 2:3:4", f24, h24, m24, s24);
        end
        pulse_shift();
        total++;
        if (f24 !== 2'd0) begin
            bad++;
            $display("FAIL shift_wrap_field got %0d want 0", f24);
        end
    endtask

    task automatic test_repeat();
        leave();
        enter(5'd1, 6'd0, 6'd0);
        pulse_shift();
        add = 1'b1;
        tick(10);
        total++;
        if (m24 !== 6'd1) begin
            bad++;
            $display("FAIL repeat_before_delay got %0d want 1", m24);
        end
        tick(1);
        total++;
        if (m24 !== 6'd2) begin
            bad++;
            $display("FAIL repeat_first got %0d want 2", m24);
        end
        tick(19);
        add = 1'b0;
        tick(2);
        total++;
        if ({h24, m24} !== {5'd1, 6'd6}) begin
            bad++;
            $display("FAIL repeat_30_cycles got h=%0d m=%0d want h=1 m=6", h24, m24);
        end
    endtask

    task automatic test_conflict();
        add = 1'b1; sub = 1'b1; tick(1);
        add = 1'b0; sub = 1'b0; tick(1);
        total++;
        if (m24 !== 6'd6) begin
            bad++;
            $display("FAIL add_sub_pulse got %0d want 6", m24);
        end
        add = 1'b1; sub = 1'b1; tick(15);
        add = 1'b0; sub = 1'b0; tick(1);
        total++;
        if (m24 !== 6'd6) begin
            bad++;
            $display("FAIL add_sub_held got %0d want 6", m24);
        end
        shift = 1'b1; add = 1'b1; tick(1);
        shift = 1'b0; add = 1'b0; tick(1);
        total++;
        if ({f24, h24, m24, s24} !== {2'd2, 5'd1, 6'd6, 6'd0}) begin
            bad++;
            $display("FAIL shift_with_add got f=%0d %0d:%0d:%0d want f=2 1:6:0", f24, h24, m24, s24);
        end
    endtask

    task automatic test_commit();
        leave();
        enter(5'd4, 6'd8, 6'd9);
        pulse_add();
        pulse_shift();
        pulse_sub();
        cur_h = 5'd20; cur_m = 6'd30; cur_s = 6'd40;
        en = 1'b0; add = 1'b1;
        tick(1);
        total++;
        if ({l24, l12, h24, m24, s24} !== {1'b1, 1'b1, 5'd5, 6'd7, 6'd9}) begin
            bad++;
            $display("FAIL commit_pulse got l24=%0d l12=%0d %0d:%0d:%0d want 1 1 5:7:9", l24, l12, h24, m24, s24);
        end
        add = 1'b0;
        tick(1);
        total++;
        if ({l24, h24, m24, s24} !== {1'b0, 5'd5, 6'd7, 6'd9}) begin
            bad++;
            $display("FAIL commit_one_cycle got l=%0d %0d:%0d:%0d want 0 5:7:9", l24, h24, m24, s24);
        end
        tick(1);
        total++;
        if ({l24, h24, m24, s24} !== {1'b0, 5'd20, 6'd30, 6'd40}) begin
            bad++;
            $display("FAIL commit_resume_track got l=%0d %0d:%0d:%0d want 0 20:30:40", l24, h24, m24, s24);
        end
    endtask

    task automatic test_reset_mid_edit();
        enter(5'd7, 6'd7, 6'd7);
        pulse_add();
        rst_n = 1'b0;
        #1;
        total++;
        if ({h24, m24, s24, f24, l24, h12} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 5'd12}) begin
            bad++;
            $display("FAIL reset_mid_edit got %0d:%0d:%0d f=%0d l=%0d h12=%0d want 0:0:0 f=0 l=0 h12=12",
                     h24, m24, s24, f24, l24, h12);
        end
        en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            total++;
            if ({l24, l12} !== 2'b00) begin
                bad++;
                $display("FAIL reset_no_load cycle=%0d got l24=%0d l12=%0d want 0 0", i, l24, l12);
            end
        end
        total++;
        if ({h24, m24, s24} !== {5'd7, 6'd7, 6'd7}) begin
            bad++;
            $display("FAIL reset_then_track got %0d:%0d:%0d want 7:7:7", h24, m24, s24);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_wrap();
        test_shift();
        test_repeat();
        test_conflict();
        test_commit();
        test_reset_mid_edit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
